// File: rtl/inst_encoder.sv
// RISC-V I/S/B-type instruction encoder that writes packed words to consecutive
// instruction-memory locations through a back-pressured write port.
module inst_encoder #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam logic [2:0] OpAddi = 3'd0;
    localparam logic [2:0] OpLw   = 3'd1;
    localparam logic [2:0] OpSw   = 3'd2;
    localparam logic [2:0] OpBeq  = 3'd3;
    localparam logic [2:0] OpBne  = 3'd4;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrRange   = 2'b01;
    localparam logic [1:0] ErrAlign   = 2'b10;
    localparam logic [1:0] ErrIllegal = 2'b11;

    localparam logic [ADDR_WIDTH:0] CountOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CountFull = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;

    // Request decode
    logic        is_itype, is_stype, is_btype, is_illegal;
    logic [2:0]  funct3;
    logic [6:0]  opcode;

    always_comb begin
        is_itype   = 1'b0;
        is_stype   = 1'b0;
        is_btype   = 1'b0;
        is_illegal = 1'b0;
        funct3     = 3'b000;
        opcode     = 7'b0000000;
        case (op)
            OpAddi: begin is_itype = 1'b1; funct3 = 3'b000; opcode = 7'b0010011; end
            OpLw:   begin is_itype = 1'b1; funct3 = 3'b010; opcode = 7'b0000011; end
            OpSw:   begin is_stype = 1'b1; funct3 = 3'b010; opcode = 7'b0100011; end
            OpBeq:  begin is_btype = 1'b1; funct3 = 3'b000; opcode = 7'b1100011; end
            OpBne:  begin is_btype = 1'b1; funct3 = 3'b001; opcode = 7'b1100011; end
            default: is_illegal = 1'b1;
        endcase
    end

    // Immediate range checks on the full 32-bit signed value
    logic signed [31:0] simm;
    logic               is_range_ok, b_range_ok;

    assign simm        = imm;
    assign is_range_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign b_range_ok  = (simm >= -32'sd4096) && (simm <= 32'sd4094);

    logic [1:0] req_code;

    always_comb begin
        req_code = ErrNone;
        if (is_illegal) begin
            req_code = ErrIllegal;
        end else if (is_btype ? !b_range_ok : !is_range_ok) begin
            req_code = ErrRange;
        end else if (is_btype && imm[0]) begin
            req_code = ErrAlign;
        end
    end

    // Instruction packing
    logic [31:0] enc_word;

    always_comb begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        if (is_stype) begin
            enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        end else if (is_btype) begin
            enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        end
    end

    assign full = (count_q == CountFull);

    // Next-state and handshake outputs
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = !full && !start;
                if (start) begin
                    count_d    = '0;
                    err_d      = 1'b0;
                    err_code_d = ErrNone;
                end else if (in_valid && in_ready) begin
                    if (req_code != ErrNone) begin
                        // Only the first error is recorded until restart
                        if (!err_q) begin
                            err_d      = 1'b1;
                            err_code_d = req_code;
                        end
                    end else begin
                        wdata_d = enc_word;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                mem_we = 1'b1;
                if (mem_ready) begin
                    count_d = count_q + CountOne;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Address wraps naturally at 2**ADDR_WIDTH
    assign mem_addr  = BASE_ADDR + count_q[ADDR_WIDTH-1:0];
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential RISC-V instruction encoder and instruction-memory loader, the inverse of the core's immediate/instruction decode path. It accepts one instruction request per handshake as an operation select plus register and immediate fields. It range-checks the immediate, packs the 32-bit instruction word (I-, S- or B-type) and writes it to consecutive instruction-memory words through a back-pressured write port. Used by the self-test/boot loader to build programs in instruction memory.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory
- BASE_ADDR, 0, first word address written after reset/start (ADDR_WIDTH bits)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  synchronous restart: count/address back to base, err cleared
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- op  in  3  0 addi, 1 lw, 2 sw, 3 beq, 4 bne, 5–7 illegal
- rd, rs1, rs2  in  5 each  register fields
- imm  in  32  signed immediate (byte offset for branches)
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts write when mem_we && mem_ready
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_WIDTH+1  words written since reset/start
- full  out  1  count == 2**ADDR_WIDTH
- err  out  1  sticky error flag
- err_code  out  2  first error: 01 range, 10 misaligned, 11 illegal op

## Operation
- FSM states:
  - IDLE: in_ready = !full && !start.
  - WRITE: in_ready = 0, mem_we = 1.
- IDLE transitions:
  - Accepted legal request: latch the encoded word into mem_wdata, go to WRITE.
  - Accepted illegal request: consumed, nothing written, stay in IDLE.
- WRITE: mem_we, mem_addr and mem_wdata are held stable until mem_ready. Then count increments and the FSM returns to IDLE.
- mem_addr = BASE_ADDR + count[ADDR_WIDTH-1:0], modulo 2**ADDR_WIDTH. No write is issued while full.
- Encoding:
  - I-type (addi funct3 000, opcode 0010011; lw funct3 010, opcode 0000011): {imm[11:0], rs1, funct3, rd, opcode}.
  - S-type (sw): {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - B-type (beq funct3 000, bne funct3 001): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
  - Unused fields are ignored: rs2 for I-type, rd for S/B.
- Checks, in priority order:
  - op ≥ 5 → code 11.
  - I/S imm outside [−2048, 2047], or B imm outside [−4096, 4094] → code 01.
  - B imm[0] = 1 → code 10.
- Error reporting: err is set on the first error. err_code holds the first error's code until start or reset; later errors do not overwrite it.
- start:
  - In IDLE: count = 0, err = 0, err_code = 00. start has priority over a simultaneous in_valid, which is not accepted that cycle.
  - In WRITE: ignored.

## Timing
- Reset values: state IDLE, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, count 0, full 0, err 0, err_code 00. in_ready is 1 once rst_n is high.
- rst_n low mid-WRITE clears mem_we immediately (asynchronous) and the pending write is dropped.
- Accept at edge N → mem_we = 1 with valid data from after edge N. If mem_ready is high in that cycle, the write completes at edge N+1: count and mem_addr update, state is IDLE, in_ready returns. Peak throughput is one word per 2 cycles.
- An error request is accepted at edge N; err and err_code are visible after edge N, and in_ready stays 1.
- full updates on the same edge as the final count increment.

## Test plan
- Reset, then addi rd=1, rs1=0, imm=5 with mem_ready=1 → mem_wdata 0x00500093 at addr BASE_ADDR, mem_we high exactly 1 cycle, count 1.
- sw rs2=2, rs1=3, imm=−4 → 0xFE21AE23. Then beq rs1=1, rs2=2, imm=−8 → 0xFE208CE3 at the next address.
- Errors:
  - addi imm=2048 → err=1, err_code=01, no mem_we, count unchanged.
  - Then beq imm=3 → err_code stays 01.
  - start → err=0, err_code=00.
  - Then op=6 → err_code=11.
- Back-pressure: hold mem_ready=0 for 3 cycles during WRITE → mem_we, mem_addr, mem_wdata stable, in_ready=0. Write completes on the cycle mem_ready rises.
- Full and restart (ADDR_WIDTH=2, BASE_ADDR=2):
  - 4 legal writes → addresses 2, 3, 0, 1; then full=1, in_ready=0 with in_valid held high.
  - start → count 0, full 0, mem_addr 2.
- start asserted together with in_valid in IDLE → request not accepted that cycle, count 0.
- rst_n pulsed low mid-WRITE → mem_we drops without a clock edge, and all outputs take their reset values.
